// File: rtl/mod_mapper_pkg.sv
// +---------------------------------------------------------------------+
// | mod_mapper_pkg: modes, bits-per-symbol lookup, Q2.14 amplitudes      |
// | Revision: 1.0                                                        |
// +---------------------------------------------------------------------+
`default_nettype none

package mod_mapper_pkg;

  typedef enum logic [1:0] {
    MODE_BPSK  = 2'd0,
    MODE_QPSK  = 2'd1,
    MODE_QAM16 = 2'd2,
    MODE_QAM64 = 2'd3
  } mode_e;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_e;

  localparam logic signed [15:0] BPSK_AMP    = 16'sd16384;
  localparam logic signed [15:0] QPSK_AMP    = 16'sd11585;
  localparam logic signed [15:0] QAM16_UNIT  = 16'sd5181;
  localparam logic signed [15:0] QAM64_UNIT  = 16'sd2528;
  localparam logic signed [15:0] QAM16_OUTER = 16'(3 * QAM16_UNIT);
  localparam logic signed [15:0] QAM64_L7    = 16'(7 * QAM64_UNIT);
  localparam logic signed [15:0] QAM64_L5    = 16'(5 * QAM64_UNIT);
  localparam logic signed [15:0] QAM64_L3    = 16'(3 * QAM64_UNIT);

  function automatic logic [2:0] bps_of(input mode_e m);
    case (m)
      MODE_BPSK:  return 3'd1;
      MODE_QPSK:  return 3'd2;
      MODE_QAM16: return 3'd4;
      default:    return 3'd6;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/mod_symbol_lut.sv
// +---------------------------------------------------------------------+
// | mod_symbol_lut: combinational LSB-first bits + mode -> (I,Q) Q2.14   |
// | Revision: 1.0                                                        |
// +---------------------------------------------------------------------+
`default_nettype none

module mod_symbol_lut
  import mod_mapper_pkg::*;
#(
  parameter int OUT_W = 16
) (
  input  mode_e                    mode,
  input  logic [5:0]               bits,
  output logic signed [OUT_W-1:0]  sym_i,
  output logic signed [OUT_W-1:0]  sym_q
);

  logic signed [15:0] i16;
  logic signed [15:0] q16;

  function automatic logic signed [15:0] axis(input logic neg, input logic signed [15:0] mag);
    return neg ? -mag : mag;
  endfunction

  function automatic logic signed [15:0] qam16_mag(input logic b);
    return b ? QAM16_UNIT : QAM16_OUTER;
  endfunction

  // Gray-coded magnitude: first bit is the more significant one
  function automatic logic signed [15:0] qam64_mag(input logic b_hi, input logic b_lo);
    case ({b_hi, b_lo})
      2'b00:   return QAM64_L7;
      2'b01:   return QAM64_L5;
      2'b11:   return QAM64_L3;
      default: return QAM64_UNIT;
    endcase
  endfunction

  always_comb begin
    i16 = '0;
    q16 = '0;
    case (mode)
      MODE_BPSK: begin
        i16 = axis(bits[0], BPSK_AMP);
      end
      MODE_QPSK: begin
        i16 = axis(bits[0], QPSK_AMP);
        q16 = axis(bits[1], QPSK_AMP);
      end
      MODE_QAM16: begin
        i16 = axis(bits[0], qam16_mag(bits[1]));
        q16 = axis(bits[2], qam16_mag(bits[3]));
      end
      default: begin
        i16 = axis(bits[0], qam64_mag(bits[1], bits[2]));
        q16 = axis(bits[3], qam64_mag(bits[4], bits[5]));
      end
    endcase
  end

  assign sym_i = OUT_W'(i16);
  assign sym_q = OUT_W'(q16);

endmodule

`default_nettype wire

// File: rtl/mod_mapper_stream.sv
// +---------------------------------------------------------------------+
// | mod_mapper_stream: bit-buffered word stream to BPSK/QPSK/QAM symbols |
// | Optional macro MAPPER_SYMCNT_EN adds a 32-bit transfer counter.      |
// | Revision: 1.0                                                        |
// +---------------------------------------------------------------------+
`default_nettype none

module mod_mapper_stream
  import mod_mapper_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 16,
  parameter int BUF_W = 2 * IN_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic [1:0]               mode,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [IN_W-1:0]          data_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [OUT_W-1:0]  channel_i,
  output logic signed [OUT_W-1:0]  channel_q
`ifdef MAPPER_SYMCNT_EN
  ,
  output logic [31:0]              sym_cnt
`endif
);

  localparam int CNT_W = $clog2(BUF_W + 1);

  logic [CNT_W-1:0]        count_q;
  logic [CNT_W-1:0]        count_d;
  logic [BUF_W-1:0]        bit_buf_q;
  logic [BUF_W-1:0]        bit_buf_d;
  logic                    valid_d;
  mode_e                   mode_q;
  state_e                  state_q;
  state_e                  state_d;
  logic                    accept;
  logic                    pop;
  logic [CNT_W-1:0]        bps_w;
  logic [CNT_W-1:0]        pop_w;
  logic signed [OUT_W-1:0] lut_i;
  logic signed [OUT_W-1:0] lut_q;

  assign bps_w    = CNT_W'(bps_of(mode_q));
  assign in_ready = rst_n & enable & !flush & (count_q <= CNT_W'(BUF_W - IN_W));
  assign accept   = in_valid & in_ready;
  assign pop      = enable & !flush & (count_q >= bps_w) & (!out_valid | out_ready);
  assign pop_w    = pop ? bps_w : '0;

  mod_symbol_lut #(
    .OUT_W (OUT_W)
  ) u_lut (
    .mode  (mode_q),
    .bits  (bit_buf_q[5:0]),
    .sym_i (lut_i),
    .sym_q (lut_q)
  );

  // New bits land just above what survives this cycle's pop
  always_comb begin
    count_d   = count_q;
    bit_buf_d = bit_buf_q;
    valid_d   = out_valid;
    if (flush) begin
      count_d   = '0;
      bit_buf_d = '0;
      valid_d   = 1'b0;
    end else if (enable) begin
      count_d   = count_q - pop_w + (accept ? CNT_W'(IN_W) : '0);
      bit_buf_d = bit_buf_q >> pop_w;
      if (accept) begin
        bit_buf_d = bit_buf_d | (BUF_W'(data_in) << (count_q - pop_w));
      end
      if (pop) begin
        valid_d = 1'b1;
      end else if (out_ready) begin
        valid_d = 1'b0;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:   if (accept) state_d = ST_ACTIVE;
        ST_ACTIVE: if (count_d == '0 && !valid_d) state_d = ST_IDLE;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q   <= '0;
      bit_buf_q <= '0;
      out_valid <= 1'b0;
      channel_i <= '0;
      channel_q <= '0;
      mode_q    <= MODE_BPSK;
    end else begin
      count_q   <= count_d;
      bit_buf_q <= bit_buf_d;
      out_valid <= valid_d;
      if (pop) begin
        channel_i <= lut_i;
        channel_q <= lut_q;
      end
      if (flush) begin
        mode_q <= MODE_BPSK;
      end else if (accept && state_q == ST_IDLE) begin
        mode_q <= mode_e'(mode);
      end
    end
  end

`ifdef MAPPER_SYMCNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      sym_cnt <= '0;
    end else if (enable && out_valid && out_ready) begin
      sym_cnt <= sym_cnt + 32'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_mod_mapper_stream.sv
// +---------------------------------------------------------------------+
// | tb_mod_mapper_stream: directed + random stimulus vs bit-queue model  |
// | Revision: 1.0                                                        |
// +---------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_mod_mapper_stream;

  localparam int IN_W  = 16;
  localparam int OUT_W = 16;
  localparam int BUF_W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic flush = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [IN_W-1:0] data_in = '0;
  logic in_ready;
  logic out_valid;
  logic signed [OUT_W-1:0] channel_i;
  logic signed [OUT_W-1:0] channel_q;
`ifdef MAPPER_SYMCNT_EN
  logic [31:0] sym_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  bit bq[$];
  int m_mode = 0;
  bit m_valid = 1'b0;
  int m_i = 0;
  int m_q = 0;
  bit live = 1'b0;
  int cap_i[$];
  int cap_q[$];

  always #5 clk = ~clk;

  mod_mapper_stream #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W),
    .BUF_W (BUF_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .mode      (mode),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .channel_i (channel_i),
    .channel_q (channel_q)
`ifdef MAPPER_SYMCNT_EN
    ,
    .sym_cnt   (sym_cnt)
`endif
  );

  function automatic void check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      if (n_err <= 40) $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic int sgn(input bit b);
    return b ? -1 : 1;
  endfunction

  // Gray code to binary, then binary 0..3 maps to amplitude levels 7,5,3,1
  function automatic int lvl64(input bit g_hi, input bit g_lo);
    int b_hi;
    int b_lo;
    b_hi = int'(g_hi);
    b_lo = int'(g_hi ^ g_lo);
    return 7 - 2 * (2 * b_hi + b_lo);
  endfunction

  function automatic int bps_tbl(input int m);
    return (m == 0) ? 1 : (m == 1) ? 2 : (m == 2) ? 4 : 6;
  endfunction

  function automatic void map_sym(input int m, input logic [5:0] b, output int si, output int sq);
    case (m)
      0: begin si = sgn(b[0]) * 16384; sq = 0; end
      1: begin si = sgn(b[0]) * 11585; sq = sgn(b[1]) * 11585; end
      2: begin
        si = sgn(b[0]) * (b[1] ? 1 : 3) * 5181;
        sq = sgn(b[2]) * (b[3] ? 1 : 3) * 5181;
      end
      default: begin
        si = sgn(b[0]) * lvl64(b[1], b[2]) * 2528;
        sq = sgn(b[3]) * lvl64(b[4], b[5]) * 2528;
      end
    endcase
  endfunction

  always @(posedge clk) begin
    int bps;
    bit acc;
    bit pop;
    bit idle;
    logic [5:0] sb;
    if (!rst_n) begin
      bq.delete();
      m_valid = 1'b0;
      m_i = 0;
      m_q = 0;
      m_mode = 0;
      live = 1'b1;
    end else if (flush) begin
      bq.delete();
      m_valid = 1'b0;
      m_mode = 0;
    end else if (enable) begin
      bps  = bps_tbl(m_mode);
      acc  = in_valid && (bq.size() <= BUF_W - IN_W);
      idle = (bq.size() == 0) && !m_valid;
      pop  = (bq.size() >= bps) && (!m_valid || out_ready);
      if (pop) begin
        sb = '0;
        for (int k = 0; k < bps; k++) sb[k] = bq.pop_front();
        map_sym(m_mode, sb, m_i, m_q);
        m_valid = 1'b1;
      end else if (out_ready) begin
        m_valid = 1'b0;
      end
      if (acc) begin
        if (idle) m_mode = int'(mode);
        for (int k = 0; k < IN_W; k++) bq.push_back(data_in[k]);
      end
    end
  end

  always @(negedge clk) begin
    if (live) begin
      check("out_valid", out_valid, m_valid);
      check("in_ready", in_ready, rst_n && enable && !flush && (bq.size() <= BUF_W - IN_W));
      if (m_valid) begin
        check("channel_i", channel_i, m_i);
        check("channel_q", channel_q, m_q);
      end
      if (rst_n && enable && !flush && out_valid && out_ready) begin
        cap_i.push_back(int'(channel_i));
        cap_q.push_back(int'(channel_q));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_cap();
    cap_i.delete();
    cap_q.delete();
  endtask

  task automatic send_word(input logic [1:0] m, input logic [IN_W-1:0] d);
    int n;
    n = 0;
    mode = m;
    data_in = d;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("send_timeout", longint'(n >= 50), 0);
    @(posedge clk);
    #2;
    in_valid = 1'b0;
  endtask

  task automatic wait_syms(input int n, input int budget);
    int c;
    c = 0;
    while (cap_i.size() < n && c < budget) begin
      @(posedge clk);
      c++;
    end
    check("sym_timeout", longint'(cap_i.size() >= n), 1);
    #2;
  endtask

  function automatic int cap_at(input int k, input bit q_axis);
    if (k >= cap_i.size()) return -99999;
    return q_axis ? cap_q[k] : cap_i[k];
  endfunction

  initial begin
    int ti;
    int tq;
    int exp_i[8];
    int exp_q[8];
    int n;

    map_sym(3, 6'b000000, ti, tq);
    check("model_qam64_i", ti, 17696);
    map_sym(2, 6'b001111, ti, tq);
    check("model_qam16_q", tq, -5181);
    map_sym(3, 6'b101010, ti, tq);
    check("model_qam64_mix_i", ti, 2528);
    check("model_qam64_mix_q", tq, -12640);

    enable = 1'b1;
    out_ready = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_channel_i", channel_i, 0);
    check("rst_channel_q", channel_q, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // QPSK zeros: latency and eight identical symbols
    clear_cap();
    send_word(2'd1, 16'h0000);
    @(negedge clk);
    check("latency_edge1", out_valid, 0);
    @(negedge clk);
    check("latency_edge2", out_valid, 1);
    tick();
    wait_syms(8, 40);
    repeat (10) tick();
    check("qpsk_count", cap_i.size(), 8);
    for (int k = 0; k < 8; k++) begin
      check("qpsk_i", cap_at(k, 0), 11585);
      check("qpsk_q", cap_at(k, 1), 11585);
    end

    clear_cap();
    send_word(2'd0, 16'hAAAA);
    wait_syms(16, 60);
    repeat (5) tick();
    check("bpsk_count", cap_i.size(), 16);
    for (int k = 0; k < 16; k++) begin
      check("bpsk_i", cap_at(k, 0), (k % 2 == 0) ? 16384 : -16384);
      check("bpsk_q", cap_at(k, 1), 0);
    end

    clear_cap();
    send_word(2'd2, 16'h0F0F);
    wait_syms(4, 40);
    repeat (5) tick();
    check("qam16_s0_i", cap_at(0, 0), -5181);
    check("qam16_s0_q", cap_at(0, 1), -5181);
    check("qam16_s1_i", cap_at(1, 0), 15543);
    check("qam16_s1_q", cap_at(1, 1), 15543);

    clear_cap();
    for (int w = 0; w < 3; w++) send_word(2'd3, 16'h0000);
    wait_syms(8, 80);
    repeat (10) tick();
    check("qam64_count", cap_i.size(), 8);
    for (int k = 0; k < 8; k++) begin
      check("qam64_i", cap_at(k, 0), 17696);
      check("qam64_q", cap_at(k, 1), 17696);
    end
    check("qam64_drained", dut.count_q, 0);

    // Back-pressure: symbol 2 of 16'h1234 in QPSK is (-,-)
    exp_i = '{11585, -11585, -11585, 11585, 11585, 11585, -11585, 11585};
    exp_q = '{11585, 11585, -11585, 11585, -11585, 11585, 11585, 11585};
    clear_cap();
    send_word(2'd1, 16'h1234);
    wait_syms(2, 40);
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_valid", out_valid, 1);
      check("stall_i", channel_i, -11585);
      check("stall_q", channel_q, -11585);
    end
    tick();
    out_ready = 1'b1;
    wait_syms(8, 40);
    repeat (10) tick();
    check("stall_count", cap_i.size(), 8);
    for (int k = 0; k < 8; k++) begin
      check("stall_seq_i", cap_at(k, 0), exp_i[k]);
      check("stall_seq_q", cap_at(k, 1), exp_q[k]);
    end

    // Flush with 10 bits buffered while the requested mode moves to 16QAM
    send_word(2'd1, 16'h0000);
    n = 0;
    while (bq.size() != 10 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("flush_setup", bq.size(), 10);
    #1;
    mode = 2'd2;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    @(negedge clk);
    check("flush_out_valid", out_valid, 0);
    check("flush_in_ready", in_ready, 1);
    tick();
    clear_cap();
    send_word(2'd2, 16'h0F0F);
    wait_syms(4, 40);
    repeat (5) tick();
    check("post_flush_count", cap_i.size(), 4);
    check("post_flush_i", cap_at(0, 0), -5181);
    check("post_flush_q", cap_at(0, 1), -5181);

    for (int c = 0; c < 4000; c++) begin
      rst_n     = ($urandom_range(0, 299) != 0);
      flush     = ($urandom_range(0, 59) == 0);
      enable    = ($urandom_range(0, 7) != 0);
      in_valid  = ($urandom_range(0, 2) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
      data_in   = 16'($urandom);
      tick();
    end

    rst_n = 1'b1;
    flush = 1'b0;
    enable = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (40) tick();
    check("final_drained", out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
